// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with one-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/flush counters.
module pipe_stage_skid #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int                CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_fire;

  // in_ready is built only from registers and en/flush, never from out_ready.
  assign in_ready  = en & ~s_valid_q & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (en) begin
      if (flush) begin
        m_valid_d = 1'b0;
        s_valid_d = 1'b0;
        m_data_d  = BUBBLE;
        s_data_d  = BUBBLE;
      end else if (!m_valid_q || out_ready) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
          s_data_d  = BUBBLE;
        end else if (in_fire) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end else begin
          m_valid_d = 1'b0;
          m_data_d  = BUBBLE;
        end
      end else if (in_fire) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= BUBBLE;
      s_data_q  <= BUBBLE;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Counters saturate at all-ones and are cleared only by reset.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (en && m_valid_q && !out_ready && !(&stall_q)) stall_d = stall_q + CNT_ONE;
    if (en && flush && !(&flush_q))                   flush_d = flush_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid against a 2-deep FIFO model.
// Build with or without PIPE_STAGE_PERF_EN; counter expectations follow the macro.
module tb_pipe_stage_skid;

  localparam int         DW      = 8;
  localparam int         CW      = 4;
  localparam logic [7:0] BUB     = 8'hEE;
  localparam int         CNT_MAX = (1 << CW) - 1;

  logic          clk, rstn, en, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_stall = 0;
  int            exp_flush = 0;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge, then advances the model.
  initial begin
    forever begin
      int            sz;
      logic [DW-1:0] head;
      @(negedge clk);
      #4;
      if (!rstn) begin
        exp_q.delete();
        exp_stall = 0;
        exp_flush = 0;
      end
      sz   = exp_q.size();
      head = (sz > 0) ? exp_q[0] : BUB;
      check("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
      check("out_data", {24'd0, out_data}, {24'd0, head});
      check("occupancy", {30'd0, occupancy}, sz);
      check("in_ready", {31'd0, in_ready}, {31'd0, en && !flush && sz < 2});
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cycles", {28'd0, stall_cycles}, exp_stall);
      check("flush_count", {28'd0, flush_count}, exp_flush);
`else
      check("stall_cycles", {28'd0, stall_cycles}, 0);
      check("flush_count", {28'd0, flush_count}, 0);
`endif
      if (rstn && en) begin
        if (sz > 0 && !out_ready && exp_stall < CNT_MAX) exp_stall++;
        if (flush && exp_flush < CNT_MAX) exp_flush++;
        if (flush) begin
          exp_q.delete();
        end else begin
          if (sz > 0 && out_ready) void'(exp_q.pop_front());
          if (in_valid && sz < 2) exp_q.push_back(in_data);
        end
      end
    end
  end

  task automatic step(input logic e, input logic f, input logic iv,
                      input logic [DW-1:0] d, input logic ordy);
    en        = e;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) step(1, 0, 0, 8'h00, 0);
    rstn = 1'b1;
    step(1, 0, 0, 8'h00, 0);

    // Asynchronous reset with two payloads held
    step(1, 0, 1, 8'hA5, 0);
    step(1, 0, 1, 8'h5A, 0);
    in_valid = 1'b0;
    check("preload_occ", {30'd0, occupancy}, 2);
    #1;
    rstn = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 0);
    check("async_out_data", {24'd0, out_data}, {24'd0, BUB});
    check("async_occ", {30'd0, occupancy}, 0);
    check("async_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    #1;
    rstn = 1'b1;

    // Streaming
    for (int i = 1; i <= 8; i++) step(1, 0, 1, DW'(i), 1);
    repeat (2) step(1, 0, 0, 8'h00, 1);

    // Skid capture and release
    step(1, 0, 1, 8'h10, 1);
    step(1, 0, 1, 8'h11, 0);
    step(1, 0, 1, 8'h12, 0);
    check("skid_occ", {30'd0, occupancy}, 2);
    check("skid_in_ready", {31'd0, in_ready}, 0);
    step(1, 0, 1, 8'h12, 0);
    step(1, 0, 1, 8'h12, 1);
    step(1, 0, 1, 8'h12, 1);
    repeat (2) step(1, 0, 0, 8'h00, 1);

    // Flush while full
    step(1, 0, 1, 8'h20, 0);
    step(1, 0, 1, 8'h21, 0);
    step(1, 1, 1, 8'h22, 1);
    check("flush_occ", {30'd0, occupancy}, 0);
    check("flush_data", {24'd0, out_data}, {24'd0, BUB});
    step(1, 0, 1, 8'h22, 1);
    repeat (2) step(1, 0, 0, 8'h00, 1);

    // Enable freeze
    step(1, 0, 1, 8'h30, 0);
    repeat (3) step(0, 0, 1, 8'h31, 1);
    check("freeze_data", {24'd0, out_data}, 8'h30);
    step(1, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 1);

    // Flush with en low must hold
    step(1, 0, 1, 8'h40, 0);
    repeat (2) step(0, 1, 1, 8'h41, 1);
    check("hold_flush_occ", {30'd0, occupancy}, 1);
    step(1, 0, 0, 8'h00, 1);

    // Stall saturation and second flush
    step(1, 0, 1, 8'h50, 0);
    repeat (20) step(1, 0, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_sat", {28'd0, stall_cycles}, 32'hF);
    check("flush_two", {28'd0, flush_count}, 2);
`else
    check("stall_off", {28'd0, stall_cycles}, 0);
    check("flush_off", {28'd0, flush_count}, 0);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) != 0, ($urandom % 25) == 0, $urandom % 2,
           DW'($urandom), ($urandom % 3) != 0);
    end
    repeat (4) step(1, 0, 0, 8'h00, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
